// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux: NCH producer channels in, one registered consumer port out.
interface rr_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic [SELW-1:0]      out_chan;
  logic                 out_ready;

  // The mux itself
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );

  // Producers and consumer around the mux
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/rr_mux.sv
// N-channel output-registered mux with fixed-select or round-robin arbitration and a
// single-entry output register that accepts a new word on the same edge it is drained.
module rr_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic   clk,
  input  logic   rst,
  rr_mux_if.slave bus
);
  localparam logic [SELW:0]   NCH_W   = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] PTR_RST = SELW'(NCH - 1);

  logic [WIDTH-1:0] chan_data [NCH];
  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_chan_reg;
  logic             out_valid_reg;
  logic [SELW-1:0]  ptr_reg;

  logic [SELW-1:0]  rr_grant;
  logic             rr_found;
  logic [SELW-1:0]  grant;
  logic             grant_ok;
  logic             load_en;
  logic             accept;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
    assign chan_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
  end

  // Two-pass priority search: channels above ptr first, then wrap to those at or below it,
  // so ptr itself is considered last.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!rr_found && bus.in_valid[k] && (SELW'(k) > ptr_reg)) begin
        rr_found = 1'b1;
        rr_grant = SELW'(k);
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (!rr_found && bus.in_valid[k] && (SELW'(k) <= ptr_reg)) begin
        rr_found = 1'b1;
        rr_grant = SELW'(k);
      end
    end
  end

  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    if (bus.mode) begin
      grant    = rr_grant;
      grant_ok = rr_found;
    end else begin
      grant = bus.sel;
      if ({1'b0, bus.sel} < NCH_W) begin
        grant_ok = bus.in_valid[bus.sel];
      end
    end
  end

  assign load_en = !rst && (!out_valid_reg || bus.out_ready);
  assign accept  = load_en && grant_ok;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
    assign bus.in_ready[gi] = accept && (grant == SELW'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= PTR_RST;
    end else if (accept) begin
      out_data_reg  <= chan_data[grant];
      out_chan_reg  <= grant;
      out_valid_reg <= 1'b1;
      ptr_reg       <= grant;
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_chan  = out_chan_reg;
  assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_rr_mux.sv
// Directed vector bench for rr_mux: a 4-channel table plus a 3-channel hand sequence.
module tb_rr_mux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux_if #(.WIDTH(32), .NCH(4)) bus4 ();
  rr_mux_if #(.WIDTH(32), .NCH(3)) bus3 ();

  rr_mux #(.WIDTH(32), .NCH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  rr_mux #(.WIDTH(32), .NCH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    logic         rst;
    logic         mode;
    logic [1:0]   sel;
    logic [3:0]   vld;
    logic         ordy;
    logic [127:0] data;
    logic [3:0]   exp_rdy;
    logic         exp_ov;
    logic [31:0]  exp_od;
    logic [1:0]   exp_oc;
  } vec_t;

  localparam logic [127:0] D_RR  = {32'h103, 32'h102, 32'h101, 32'h100};
  localparam logic [127:0] D_FIX = {32'h3, 32'hA5A5_0002, 32'h1, 32'h0};
  localparam logic [127:0] D_BP  = {32'h103, 32'h102, 32'hDEAD_BEEF, 32'h100};
  localparam logic [95:0]  D3    = {32'h202, 32'h201, 32'h200};

  vec_t tv[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic apply4(input vec_t v, input int idx);
    @(negedge clk);
    rst            = v.rst;
    bus4.mode      = v.mode;
    bus4.sel       = v.sel;
    bus4.in_valid  = v.vld;
    bus4.out_ready = v.ordy;
    bus4.in_data   = v.data;
    #1;
    chk("in_ready", idx, 32'(bus4.in_ready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk("out_valid", idx, 32'(bus4.out_valid), 32'(v.exp_ov));
    chk("out_data", idx, bus4.out_data, v.exp_od);
    chk("out_chan", idx, 32'(bus4.out_chan), 32'(v.exp_oc));
    n_vec++;
    $display("vec %0d: rdy=%b ov=%b od=%h oc=%0d", idx, bus4.in_ready,
             bus4.out_valid, bus4.out_data, bus4.out_chan);
  endtask

  task automatic apply3(input logic r, input logic m, input logic [1:0] s, input logic [2:0] vld,
                        input logic [2:0] exp_rdy, input logic exp_ov,
                        input logic [31:0] exp_od, input logic [1:0] exp_oc, input int idx);
    @(negedge clk);
    rst            = r;
    bus3.mode      = m;
    bus3.sel       = s;
    bus3.in_valid  = vld;
    bus3.out_ready = 1'b1;
    bus3.in_data   = D3;
    #1;
    chk("nch3_in_ready", idx, 32'(bus3.in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    chk("nch3_out_valid", idx, 32'(bus3.out_valid), 32'(exp_ov));
    chk("nch3_out_data", idx, bus3.out_data, exp_od);
    chk("nch3_out_chan", idx, 32'(bus3.out_chan), 32'(exp_oc));
    n_vec++;
    $display("nch3 vec %0d: rdy=%b ov=%b od=%h oc=%0d", idx, bus3.in_ready,
             bus3.out_valid, bus3.out_data, bus3.out_chan);
  endtask

  initial begin
    rst = 1'b1;
    bus4.mode = 1'b0; bus4.sel = '0; bus4.in_valid = '0; bus4.out_ready = 1'b0; bus4.in_data = '0;
    bus3.mode = 1'b0; bus3.sel = '0; bus3.in_valid = '0; bus3.out_ready = 1'b0; bus3.in_data = '0;

    //            rst   mode  sel    vld      ordy  data   rdy      ov    od              oc
    tv.push_back('{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, D_RR,  4'b0000, 1'b0, 32'h0,          2'd0});
    tv.push_back('{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, D_RR,  4'b0000, 1'b0, 32'h0,          2'd0});
    // round-robin rotation from reset pointer
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, D_RR,  4'b0001, 1'b1, 32'h100,        2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, D_RR,  4'b0010, 1'b1, 32'h101,        2'd1});
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, D_RR,  4'b0100, 1'b1, 32'h102,        2'd2});
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, D_RR,  4'b1000, 1'b1, 32'h103,        2'd3});
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, D_RR,  4'b0001, 1'b1, 32'h100,        2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, D_RR,  4'b0010, 1'b1, 32'h101,        2'd1});
    // single valid channel wins every cycle, including when it equals ptr
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b0100, 1'b1, D_RR,  4'b0100, 1'b1, 32'h102,        2'd2});
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b0100, 1'b1, D_RR,  4'b0100, 1'b1, 32'h102,        2'd2});
    // fixed select, then select an idle channel: drain only
    tv.push_back('{1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, D_FIX, 4'b0100, 1'b1, 32'hA5A5_0002,  2'd2});
    tv.push_back('{1'b0, 1'b0, 2'd1, 4'b1101, 1'b1, D_FIX, 4'b0000, 1'b0, 32'hA5A5_0002,  2'd2});
    // backpressure: load channel 1, stall 3 cycles, release grants channel 2
    tv.push_back('{1'b0, 1'b0, 2'd1, 4'b1111, 1'b1, D_BP,  4'b0010, 1'b1, 32'hDEAD_BEEF,  2'd1});
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, D_BP,  4'b0000, 1'b1, 32'hDEAD_BEEF,  2'd1});
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, D_BP,  4'b0000, 1'b1, 32'hDEAD_BEEF,  2'd1});
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, D_BP,  4'b0000, 1'b1, 32'hDEAD_BEEF,  2'd1});
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, D_BP,  4'b0100, 1'b1, 32'h102,        2'd2});
    // drain with nothing valid
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, D_BP,  4'b0000, 1'b0, 32'h102,        2'd2});
    // load, stall, reset mid-stall, then first grant restarts at channel 0
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, D_BP,  4'b1000, 1'b1, 32'h103,        2'd3});
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, D_BP,  4'b0000, 1'b1, 32'h103,        2'd3});
    tv.push_back('{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, D_BP,  4'b0000, 1'b0, 32'h0,          2'd0});
    tv.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, D_RR,  4'b0001, 1'b1, 32'h100,        2'd0});

    for (int i = 0; i < tv.size(); i++) begin
      apply4(tv[i], i);
    end
    bus4.in_valid = '0;

    // three-channel instance: wrap at NCH, out-of-range select
    apply3(1'b1, 1'b1, 2'd0, 3'b111, 3'b000, 1'b0, 32'h0,   2'd0, 0);
    apply3(1'b0, 1'b1, 2'd0, 3'b111, 3'b001, 1'b1, 32'h200, 2'd0, 1);
    apply3(1'b0, 1'b1, 2'd0, 3'b111, 3'b010, 1'b1, 32'h201, 2'd1, 2);
    apply3(1'b0, 1'b1, 2'd0, 3'b111, 3'b100, 1'b1, 32'h202, 2'd2, 3);
    apply3(1'b0, 1'b1, 2'd0, 3'b111, 3'b001, 1'b1, 32'h200, 2'd0, 4);
    apply3(1'b0, 1'b1, 2'd0, 3'b111, 3'b010, 1'b1, 32'h201, 2'd1, 5);
    apply3(1'b0, 1'b0, 2'd3, 3'b111, 3'b000, 1'b0, 32'h201, 2'd1, 6);
    apply3(1'b0, 1'b0, 2'd2, 3'b111, 3'b100, 1'b1, 32'h202, 2'd2, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-channel, WIDTH-bit output-registered multiplexer for the SISC datapath. It generalises the 4:1 32-bit select mux with per-channel valid/ready handshakes, a fixed-select or round-robin arbitration mode, and a single-entry output register with backpressure. It sits where several producers share one consumer port, for example memory, writeback or bus access.

## Interface
Parameters:
- WIDTH, 32, data width per channel.
- NCH, 4, number of input channels (≥2; need not be a power of two).
- SELW, $clog2(NCH), derived select width; never overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  NCH  channel k presents a word.
- in_ready  out  NCH  channel k's word is accepted this cycle; at most one bit set.
- mode  in  1  0 = fixed select by sel; 1 = round-robin among valid channels.
- sel  in  SELW  channel selected when mode=0.
- out_data  out  WIDTH  registered selected word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_chan  out  SELW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts out_data this cycle.

## Operation
- State:
  - output register: out_data, out_chan, out_valid.
  - round-robin pointer ptr (SELW bits) = last granted channel.
- load_en = !out_valid || out_ready. The register can take a new word when it is empty or being drained the same cycle.
- Grant, combinational:
  - mode=0: g = sel and grant_ok = in_valid[sel].
  - mode=0, sel ≥ NCH: grant_ok = 0.
  - mode=1: g = first k with in_valid[k] set, searching ptr+1, ptr+2, … with wrap from NCH-1 to 0. ptr itself is checked last. grant_ok = |in_valid.
- in_ready[g] = load_en & grant_ok; all other bits are 0. in_ready depends combinationally on in_valid, out_ready, mode and sel. It does not depend on its own output.
- Accept (in_ready[g]=1) at the edge:
  - out_data ← channel g word, out_chan ← g, out_valid ← 1, ptr ← g.
  - ptr updates in both modes.
- Drain without accept (out_valid & out_ready & !accept): out_valid ← 0. out_data and out_chan hold their last values.
- Stall (out_valid & !out_ready): out_data, out_chan, out_valid and ptr all hold.
- Simultaneous drain and accept: the new word replaces the old one in the same edge, with no bubble.
- mode and sel changes take effect in the cycle they are presented. No state is flushed.
- ptr wraps modulo NCH, not 2^SELW. ptr never holds a value ≥ NCH.

## Timing
- Reset (rst=1 at edge) clears: out_valid=0, out_data=0, out_chan=0, ptr=NCH-1, so the first round-robin search starts at channel 0.
- While rst=1, in_ready=0.
- Reset mid-operation discards the held word regardless of out_ready. Nothing is accepted on the reset edge.
- Latency: accept at edge n → out_valid=1 with that word from edge n onward (1 cycle input-to-output).
- Throughput: one word per cycle when out_ready is held at 1.
- Fairness: in mode 1, with all channels continuously valid, each channel is granted once every NCH accepts.

## Test plan
- Reset: drive in_valid=all 1s and hold rst=1 for 2 cycles. Required: in_ready=0, out_valid=0, out_data=0, out_chan=0. After release, the first mode=1 grant is channel 0.
- Fixed select: NCH=4, mode=0, sel=2, channel 2 data 0xA5A5_0002, all channels valid, out_ready=1. Required: in_ready=4'b0100; the next cycle has out_data=0xA5A5_0002 and out_chan=2. With sel=1 and in_valid[1]=0: in_ready=0 and out_valid falls to 0.
- Round-robin rotation: mode=1, all 4 channels valid, channel k data = 0x100+k, out_ready=1 for 6 cycles. Required: out_chan sequence is 0,1,2,3,0,1 with matching data and no bubbles. With only in_valid=4'b0100 set, channel 2 is granted every cycle.
- Backpressure: load one word (channel 1, 0xDEAD_BEEF), then hold out_ready=0 for 3 cycles with all channels valid. Required: in_ready=0, out_data=0xDEAD_BEEF, out_chan=1 and ptr all stable. On out_ready=1, the next channel (2) is accepted on the same edge.
- Drain-only and reset mid-stall: with out_valid=1, out_ready=1 and in_valid=0, out_valid→0 and out_data holds. With a stalled word, assert rst. Required: out_valid=0 and out_data=0 after the edge, and nothing accepted that edge.
- Non-power-of-two: NCH=3, mode=1, all valid. Required: out_chan cycles 0,1,2,0 and never shows 3. With mode=0 and sel=3: in_ready=0.
